// File: rtl/mem_wb_stall.sv
// Memory/writeback stage: selects writeback data, extracts loads from aligned
// memory words, and stalls upstream while a load response is outstanding.
module mem_wb_stall #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15,
  parameter int RDW     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [2:0]      in_wb_op,
  input  logic [2:0]      in_funct3,
  input  logic [RDW-1:0]  in_rd,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            stall_out,
  output logic [XLEN-1:0] regs_data_out,
  output logic [RDW-1:0]  regs_wr_id_out,
  output logic            regs_write_out,
  output logic            err_out
);

  localparam int OFFW = $clog2(XLEN / 8);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic { IDLE, WAIT } state_e;
  typedef enum logic [2:0] {
    WB_NONE = 3'd0, WB_PC2 = 3'd1, WB_PC4 = 3'd2, WB_ALU = 3'd3, WB_MEM = 3'd4
  } wb_op_e;

  state_e          state;
  logic [CW-1:0]   wait_cnt;
  logic [RDW-1:0]  cap_rd;
  logic [2:0]      cap_funct3;
  logic [OFFW-1:0] cap_off;

  logic [2:0]      ld_funct3;
  logic [OFFW-1:0] ld_off;
  logic [XLEN-1:0] ld_value;
  logic            mem_bad;
  logic            wr_req;
  logic            wr_fire;
  logic [XLEN-1:0] wr_data;
  logic [RDW-1:0]  wr_rd;

  function automatic logic supported(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: return 1'b1;
      3'd3, 3'd6:                   return (XLEN == 64);
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [OFFW-1:0] off);
    case (f3)
      3'd1, 3'd5: return off[0];
      3'd2, 3'd6: return |off[1:0];
      3'd3:       return |off;
      default:    return 1'b0;
    endcase
  endfunction

  // The word arrives aligned; shift the addressed bytes down, then extend.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word,
                                              input logic [2:0] f3,
                                              input logic [OFFW-1:0] off);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh  = word >> {off, 3'b000};
    res = '0;
    case (f3)
      3'd0: begin res = {XLEN{sh[7]}};  res[7:0]  = sh[7:0];  end
      3'd1: begin res = {XLEN{sh[15]}}; res[15:0] = sh[15:0]; end
      3'd2: begin res = {XLEN{sh[31]}}; res[31:0] = sh[31:0]; end
      3'd3: res = sh;
      3'd4: res[7:0]  = sh[7:0];
      3'd5: res[15:0] = sh[15:0];
      3'd6: res[31:0] = sh[31:0];
      default: res = '0;
    endcase
    return res;
  endfunction

  assign stall_out = (state == WAIT);
  assign ld_funct3 = (state == WAIT) ? cap_funct3 : in_funct3;
  assign ld_off    = (state == WAIT) ? cap_off    : in_alu_result[OFFW-1:0];
  assign ld_value  = extract(mem_rsp_data, ld_funct3, ld_off);
  assign mem_bad   = !supported(in_funct3) || misaligned(in_funct3, in_alu_result[OFFW-1:0]);
  assign wr_fire   = wr_req && (wr_rd != '0);

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    wr_req  = 1'b0;
    wr_data = ld_value;
    wr_rd   = in_rd;
    if (state == WAIT) begin
      wr_req = mem_rsp_valid;
      wr_rd  = cap_rd;
    end else if (in_valid) begin
      case (in_wb_op)
        WB_PC2: begin wr_req = 1'b1; wr_data = in_pc + XLEN'(2); end
        WB_PC4: begin wr_req = 1'b1; wr_data = in_pc + XLEN'(4); end
        WB_ALU: begin wr_req = 1'b1; wr_data = in_alu_result;    end
        WB_MEM: wr_req = !mem_bad && mem_rsp_valid;
        default: wr_req = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      cap_rd         <= '0;
      cap_funct3     <= '0;
      cap_off        <= '0;
      regs_data_out  <= '0;
      regs_wr_id_out <= '0;
      regs_write_out <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      regs_write_out <= wr_fire;
      err_out        <= 1'b0;
      if (wr_fire) begin
        regs_data_out  <= wr_data;
        regs_wr_id_out <= wr_rd;
      end
      case (state)
        IDLE: begin
          if (in_valid && in_wb_op == WB_MEM) begin
            if (mem_bad) begin
              err_out <= 1'b1;
            end else if (!mem_rsp_valid) begin
              state      <= WAIT;
              wait_cnt   <= '0;
              cap_rd     <= in_rd;
              cap_funct3 <= in_funct3;
              cap_off    <= in_alu_result[OFFW-1:0];
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            state <= IDLE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state   <= IDLE;
            err_out <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stall.sv
// Directed bench for mem_wb_stall: expected writebacks are queued as stimulus
// is driven and popped when the DUT raises regs_write_out.
module tb_mem_wb_stall;

  localparam int XLEN = 32;
  localparam int RDW  = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [2:0]      in_wb_op;
  logic [2:0]      in_funct3;
  logic [RDW-1:0]  in_rd;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_alu_result;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            stall_out;
  logic [XLEN-1:0] regs_data_out;
  logic [RDW-1:0]  regs_wr_id_out;
  logic            regs_write_out;
  logic            err_out;

  typedef struct {
    logic [RDW-1:0]  rd;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  mem_wb_stall #(.XLEN(XLEN), .TIMEOUT(15), .RDW(RDW)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_wb_op       (in_wb_op),
    .in_funct3      (in_funct3),
    .in_rd          (in_rd),
    .in_pc          (in_pc),
    .in_alu_result  (in_alu_result),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .stall_out      (stall_out),
    .regs_data_out  (regs_data_out),
    .regs_wr_id_out (regs_wr_id_out),
    .regs_write_out (regs_write_out),
    .err_out        (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3,
                       input logic [RDW-1:0] rd, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] alu, input logic rv, input logic [XLEN-1:0] rdata);
    in_valid      = v;
    in_wb_op      = op;
    in_funct3     = f3;
    in_rd         = rd;
    in_pc         = pc;
    in_alu_result = alu;
    mem_rsp_valid = rv;
    mem_rsp_data  = rdata;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 3'd0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic expect_wb(input logic [RDW-1:0] rd, input logic [XLEN-1:0] data);
    wb_t item;
    item.rd   = rd;
    item.data = data;
    exp_q.push_back(item);
  endtask

  // Advance one clock, then compare strobes and any writeback against the queue.
  task automatic step(input string tag, input logic exp_wr, input logic exp_err, input logic exp_stall);
    wb_t item;
    @(posedge clk);
    #1;
    check({tag, ".write"}, regs_write_out, exp_wr);
    check({tag, ".err"},   err_out,        exp_err);
    check({tag, ".stall"}, stall_out,      exp_stall);
    if (regs_write_out === 1'b1 && exp_q.size() > 0) begin
      item = exp_q.pop_front();
      check({tag, ".id"},   regs_wr_id_out, item.rd);
      check({tag, ".data"}, regs_data_out,  item.data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.write", regs_write_out, 1'b0);
    check("rst.err",   err_out,        1'b0);
    check("rst.stall", stall_out,      1'b0);
    check("rst.data",  regs_data_out,  '0);
    check("rst.id",    regs_wr_id_out, '0);
    reset = 1'b0;

    // ALU writeback, then hold when idle, then rd=0 suppression
    drive(1'b1, 3'd3, 3'd0, 5'd5, 32'h0, 32'h0000_1234, 1'b0, '0);
    expect_wb(5'd5, 32'h0000_1234);
    step("alu", 1'b1, 1'b0, 1'b0);
    idle();
    step("hold", 1'b0, 1'b0, 1'b0);
    check("hold.data", regs_data_out,  32'h0000_1234);
    check("hold.id",   regs_wr_id_out, 5'd5);
    drive(1'b1, 3'd3, 3'd0, 5'd0, 32'h0, 32'h0000_5555, 1'b0, '0);
    step("alu_rd0", 1'b0, 1'b0, 1'b0);
    check("alu_rd0.data", regs_data_out, 32'h0000_1234);

    // PC-relative links, including wraparound, and WNONE
    drive(1'b1, 3'd1, 3'd0, 5'd1, 32'h0000_0100, 32'h0, 1'b0, '0);
    expect_wb(5'd1, 32'h0000_0102);
    step("pc2", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd2, 3'd0, 5'd2, 32'hFFFF_FFFE, 32'h0, 1'b0, '0);
    expect_wb(5'd2, 32'h0000_0002);
    step("pc4_wrap", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 3'd0, 5'd3, 32'h0000_0200, 32'h0000_7777, 1'b0, '0);
    step("wnone", 1'b0, 1'b0, 1'b0);

    // Same-cycle loads across sizes and offsets
    drive(1'b1, 3'd4, 3'd0, 5'd4, 32'h0, 32'h0000_1003, 1'b1, 32'h8000_0000);
    expect_wb(5'd4, 32'hFFFF_FF80);
    step("lb_off3", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 3'd1, 5'd10, 32'h0, 32'h0000_2002, 1'b1, 32'h8001_0000);
    expect_wb(5'd10, 32'hFFFF_8001);
    step("lh_off2", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 3'd4, 5'd11, 32'h0, 32'h0000_3001, 1'b1, 32'h0000_AB00);
    expect_wb(5'd11, 32'h0000_00AB);
    step("lbu_off1", 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 3'd2, 5'd12, 32'h0, 32'h0000_4000, 1'b1, 32'hDEAD_BEEF);
    expect_wb(5'd12, 32'hDEAD_BEEF);
    step("lw_off0", 1'b1, 1'b0, 1'b0);

    // Misaligned and unsupported loads: error pulse, no write, no stall
    drive(1'b1, 3'd4, 3'd2, 5'd13, 32'h0, 32'h0000_1001, 1'b1, 32'h1111_1111);
    step("lw_mis", 1'b0, 1'b1, 1'b0);
    drive(1'b1, 3'd4, 3'd1, 5'd0, 32'h0, 32'h0000_1003, 1'b0, '0);
    step("lh_mis_rd0", 1'b0, 1'b1, 1'b0);
    drive(1'b1, 3'd4, 3'd3, 5'd14, 32'h0, 32'h0000_1000, 1'b1, 32'h2222_2222);
    step("ld_unsup", 1'b0, 1'b1, 1'b0);
    drive(1'b1, 3'd4, 3'd7, 5'd14, 32'h0, 32'h0000_1000, 1'b0, '0);
    step("f3_7_unsup", 1'b0, 1'b1, 1'b0);

    // Stray response in IDLE is ignored
    drive(1'b0, 3'd0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h3333_3333);
    step("stray_rsp", 1'b0, 1'b0, 1'b0);
    check("stray_rsp.data", regs_data_out, 32'h0000_BEEF & 32'h0 | 32'hDEAD_BEEF);

    // Delayed LHU: three stall cycles, inputs ignored while waiting
    drive(1'b1, 3'd4, 3'd5, 5'd6, 32'h0, 32'h0000_5002, 1'b0, '0);
    step("lhu_wait1", 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'd3, 3'd0, 5'd7, 32'h0, 32'h0000_9999, 1'b0, '0);
    step("lhu_wait2", 1'b0, 1'b0, 1'b1);
    step("lhu_wait3", 1'b0, 1'b0, 1'b1);
    drive(1'b1, 3'd3, 3'd0, 5'd7, 32'h0, 32'h0000_9999, 1'b1, 32'hBEEF_0000);
    expect_wb(5'd6, 32'h0000_BEEF);
    step("lhu_rsp", 1'b1, 1'b0, 1'b0);
    idle();

    // Timeout: 15 stall cycles, then an error pulse with no write
    drive(1'b1, 3'd4, 3'd2, 5'd8, 32'h0, 32'h0000_6000, 1'b0, '0);
    step("to_wait", 1'b0, 1'b0, 1'b1);
    idle();
    for (int i = 0; i < 14; i++) step("to_wait", 1'b0, 1'b0, 1'b1);
    step("to_expire", 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h4444_4444);
    step("to_late_rsp", 1'b0, 1'b0, 1'b0);
    idle();

    // Reset during WAIT discards the pending load
    drive(1'b1, 3'd4, 3'd2, 5'd9, 32'h0, 32'h0000_7000, 1'b0, '0);
    step("rw_wait1", 1'b0, 1'b0, 1'b1);
    idle();
    step("rw_wait2", 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rw_async.stall", stall_out,      1'b0);
    check("rw_async.write", regs_write_out, 1'b0);
    check("rw_async.data",  regs_data_out,  '0);
    check("rw_async.id",    regs_wr_id_out, '0);
    drive(1'b0, 3'd0, 3'd0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h5555_5555);
    @(negedge clk);
    reset = 1'b0;
    step("rw_rsp", 1'b0, 1'b0, 1'b0);
    idle();
    step("rw_after", 1'b0, 1'b0, 1'b0);
    check("rw_after.data", regs_data_out,  '0);
    check("rw_after.id",   regs_wr_id_out, '0);

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
